cache_port_arbiter: RTL and testbench

- Shares one 4-way set-associative cache controller port between two requesters: A (instruction fetch) and B (data load/store).
- Grants requesters round-robin with one transaction outstanding.
- Drives the cache request handshake, routes the response back to the winner, and aborts hung transactions with a timeout error.
- Sits between the core-side ports and the cache controller.

---
 rtl/cache_port_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_port_arbiter
// Description : Shares one cache controller request port between an
//               instruction-fetch requester (A) and a data load/store
//               requester (B). Round-robin grant, one transaction in flight,
//               registered handshake towards the cache, response routed back
//               to the winner, and a timeout abort for hung transactions.
//
// Ports       : clk, rst_n                 clock / async active-low reset
//               a_req/op/addr/wdata        requester A command (held to gnt)
//               a_gnt, a_done, a_rdata,    A grant pulse, completion pulse,
//               a_err                      read data and timeout flag
//               b_*                        same set for requester B
//               c_req/op/addr/wdata        latched command to the cache
//               c_ready, c_done, c_rdata   cache accept / complete / data
//
// Revision    : 1.0 - initial release
// ============================================================================
module cache_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_op,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,

    output logic              c_req,
    output logic              c_op,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic              c_ready,
    input  logic              c_done,
    input  logic [DATA_W-1:0] c_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_ISSUE = 2'd1;
    localparam logic [1:0] C_WAIT  = 2'd2;

    // Counter value in the last cycle a transaction may still complete.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr;        // 1: B preferred on contention
    logic             r_owner;     // 1: B owns the in-flight transaction
    logic [CNT_W-1:0] r_cnt;

    logic             w_start;
    logic             w_pick_b;
    logic             w_busy;
    logic             w_done_ok;
    logic             w_timeout;
    logic             w_finish;

    logic             w_rr_nxt;
    logic             w_owner_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_a_gnt_nxt;
    logic             w_b_gnt_nxt;
    logic             w_a_done_nxt;
    logic             w_b_done_nxt;
    logic             w_a_err_nxt;
    logic             w_b_err_nxt;
    logic [DATA_W-1:0] w_a_rdata_nxt;
    logic [DATA_W-1:0] w_b_rdata_nxt;
    logic             w_c_req_nxt;
    logic             w_c_op_nxt;
    logic [ADDR_W-1:0] w_c_addr_nxt;
    logic [DATA_W-1:0] w_c_wdata_nxt;
    logic [DATA_W-1:0] w_fin_rdata;
    logic              w_fin_keep;

    // ------------------------------------------------------------------
    // Arbitration and completion decode
    // ------------------------------------------------------------------
    assign w_start   = (r_state == C_IDLE) && (a_req || b_req);
    // B wins when it is alone, or when both ask and B holds the priority.
    assign w_pick_b  = b_req && (!a_req || r_rr);
    assign w_busy    = (r_state == C_ISSUE) || (r_state == C_WAIT);
    // An accept and completion in the same ISSUE cycle finishes directly.
    assign w_done_ok = ((r_state == C_ISSUE) && c_ready && c_done) ||
                       ((r_state == C_WAIT) && c_done);
    // A real completion on the terminal count takes precedence.
    assign w_timeout = w_busy && !w_done_ok && (r_cnt == C_CNT_LAST);
    assign w_finish  = w_done_ok || w_timeout;

    // Read data handed back on completion; writes leave rdata untouched.
    assign w_fin_keep  = !w_timeout && c_op;
    assign w_fin_rdata = w_timeout ? '0 : c_rdata;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:  if (w_start) w_state_nxt = C_ISSUE;
            C_ISSUE: begin
                if (w_finish)     w_state_nxt = C_IDLE;
                else if (c_ready) w_state_nxt = C_WAIT;
            end
            C_WAIT:  if (w_finish) w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered outputs and datapath)
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_nxt      = r_rr;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_a_gnt_nxt   = 1'b0;
        w_b_gnt_nxt   = 1'b0;
        w_a_done_nxt  = 1'b0;
        w_b_done_nxt  = 1'b0;
        w_a_err_nxt   = 1'b0;
        w_b_err_nxt   = 1'b0;
        w_a_rdata_nxt = a_rdata;
        w_b_rdata_nxt = b_rdata;
        w_c_req_nxt   = c_req;
        w_c_op_nxt    = c_op;
        w_c_addr_nxt  = c_addr;
        w_c_wdata_nxt = c_wdata;

        case (r_state)
            C_IDLE: begin
                if (w_start) begin
                    w_owner_nxt   = w_pick_b;
                    w_rr_nxt      = ~w_pick_b;   // loser gets priority next
                    w_cnt_nxt     = '0;
                    w_c_req_nxt   = 1'b1;
                    w_a_gnt_nxt   = ~w_pick_b;
                    w_b_gnt_nxt   = w_pick_b;
                    w_c_op_nxt    = w_pick_b ? b_op    : a_op;
                    w_c_addr_nxt  = w_pick_b ? b_addr  : a_addr;
                    w_c_wdata_nxt = w_pick_b ? b_wdata : a_wdata;
                end
            end
            C_ISSUE, C_WAIT: begin
                if (w_finish) begin
                    w_c_req_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    if (r_owner) begin
                        w_b_done_nxt = 1'b1;
                        w_b_err_nxt  = w_timeout;
                        if (!w_fin_keep) w_b_rdata_nxt = w_fin_rdata;
                    end else begin
                        w_a_done_nxt = 1'b1;
                        w_a_err_nxt  = w_timeout;
                        if (!w_fin_keep) w_a_rdata_nxt = w_fin_rdata;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if ((r_state == C_ISSUE) && c_ready) w_c_req_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_cnt   <= '0;
            a_gnt   <= 1'b0;
            b_gnt   <= 1'b0;
            a_done  <= 1'b0;
            b_done  <= 1'b0;
            a_err   <= 1'b0;
            b_err   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            c_req   <= 1'b0;
            c_op    <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
        end else begin
            r_rr    <= w_rr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            a_gnt   <= w_a_gnt_nxt;
            b_gnt   <= w_b_gnt_nxt;
            a_done  <= w_a_done_nxt;
            b_done  <= w_b_done_nxt;
            a_err   <= w_a_err_nxt;
            b_err   <= w_b_err_nxt;
            a_rdata <= w_a_rdata_nxt;
            b_rdata <= w_b_rdata_nxt;
            c_req   <= w_c_req_nxt;
            c_op    <= w_c_op_nxt;
            c_addr  <= w_c_addr_nxt;
            c_wdata <= w_c_wdata_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_port_arbiter
// Description : Self-checking bench for cache_port_arbiter. A small cache
//               responder answers requests; completions are checked against
//               a scoreboard of expected results queued with each request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;

    logic              a_req = 1'b0, a_op = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    wire               a_gnt, a_done, a_err;
    wire  [DATA_W-1:0] a_rdata;

    logic              b_req = 1'b0, b_op = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    wire               b_gnt, b_done, b_err;
    wire  [DATA_W-1:0] b_rdata;

    wire               c_req, c_op;
    wire  [ADDR_W-1:0] c_addr;
    wire  [DATA_W-1:0] c_wdata;
    logic              c_ready = 1'b0;
    logic              resp_done = 1'b0;
    logic              inject_done = 1'b0;
    wire               c_done = resp_done | inject_done;
    logic [DATA_W-1:0] c_rdata = '0;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    typedef struct {
        bit          who;     // 0 = A, 1 = B
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    cache_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_req  (a_req),
        .a_op   (a_op),
        .a_addr (a_addr),
        .a_wdata(a_wdata),
        .a_gnt  (a_gnt),
        .a_done (a_done),
        .a_rdata(a_rdata),
        .a_err  (a_err),
        .b_req  (b_req),
        .b_op   (b_op),
        .b_addr (b_addr),
        .b_wdata(b_wdata),
        .b_gnt  (b_gnt),
        .b_done (b_done),
        .b_rdata(b_rdata),
        .b_err  (b_err),
        .c_req  (c_req),
        .c_op   (c_op),
        .c_addr (c_addr),
        .c_wdata(c_wdata),
        .c_ready(c_ready),
        .c_done (c_done),
        .c_rdata(c_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Cache responder: holds c_ready low for rdy_wait cycles of c_req,
    // then accepts and completes one cycle later (unless muted).
    // ------------------------------------------------------------------
    int                rdy_wait = 0;
    int                rdy_cnt  = 0;
    bit                mute     = 1'b0;
    bit                pend     = 1'b0;
    logic              lop;
    logic [31:0]       laddr, lwdata;
    logic [31:0]       mem [bit [31:0]];

    always begin
        @(posedge clk);
        #1;
        resp_done = 1'b0;
        c_ready   = 1'b0;
        if (!rst_n) begin
            pend    = 1'b0;
            rdy_cnt = 0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (!mute) begin
                    resp_done = 1'b1;
                    c_rdata   = mem.exists(laddr) ? mem[laddr] : 32'd0;
                    if (lop) mem[laddr] = lwdata;
                end
            end
            if (c_req) begin
                if (rdy_cnt < rdy_wait) begin
                    rdy_cnt++;
                end else begin
                    c_ready = 1'b1;
                    rdy_cnt = 0;
                    pend    = 1'b1;
                    lop     = c_op;
                    laddr   = c_addr;
                    lwdata  = c_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus / observation helpers (no comparisons inside)
    // ------------------------------------------------------------------
    function automatic bit probe(input int sel);
        case (sel)
            0:       return a_gnt | b_gnt;
            1:       return a_done | b_done;
            default: return 1'b0;
        endcase
    endfunction

    // Returns the cycle stamp of the first negedge where probe(sel) holds,
    // or -1 when the bound runs out.
    task automatic wait_sig(input int sel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (probe(sel)) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic drive_req(input bit who, input bit op,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        if (who) begin
            b_req = 1'b1; b_op = op; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_op = op; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic push_exp(input bit who, input bit err, input logic [31:0] rdata);
        exp_t e;
        e.who = who; e.err = err; e.rdata = rdata;
        sb.push_back(e);
    endtask

    function automatic logic [135:0] all_outs();
        return {a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
                c_req, c_op, c_addr, c_wdata};
    endfunction

    function automatic logic [34:0] done_obs();
        return {a_done, b_done, b_done ? b_err : a_err, b_done ? b_rdata : a_rdata};
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int t0, g, d;
        exp_t e;
        // write 111 to 64, then read it back
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 1'b0, (k == 0) ? 32'd0 : 32'd111);
            drive_req(1'b0, (k == 0), 32'd64, 32'd111);
            t0 = cyc;
            wait_sig(0, 20, g);
            vectors++;
            if (g !== t0 + 1 || {a_gnt, b_gnt, c_req, c_op, c_addr} !== {3'b101, (k == 0), 32'd64}) begin
                errors++;
                $display("FAIL wr_rd_grant[%0d]: got cyc %0d gnt %b%b req %b op %b addr %0d expected cyc %0d A gnt op %0d addr 64",
                         k, g, a_gnt, b_gnt, c_req, c_op, c_addr, t0 + 1, (k == 0));
            end
            a_req = 1'b0;
            wait_sig(1, 20, d);
            e = sb.pop_front();
            vectors++;
            if (d !== g + 2 || done_obs() !== {~e.who, e.who, e.err, e.rdata}) begin
                errors++;
                $display("FAIL wr_rd_done[%0d]: got cyc %0d obs %h expected cyc %0d obs %h",
                         k, d, done_obs(), g + 2, {~e.who, e.who, e.err, e.rdata});
            end
        end
    endtask

    task automatic test_contention();
        int g, d;
        exp_t e;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mem[32'd1088] = 32'h0000_A5A5;
        mem[32'd2112] = 32'h0000_5A5A;
        for (int i = 0; i < 4; i++)
            push_exp(i[0], 1'b0, i[0] ? 32'h0000_5A5A : 32'h0000_A5A5);
        @(negedge clk);
        a_req = 1'b1; a_op = 1'b0; a_addr = 32'd1088;
        b_req = 1'b1; b_op = 1'b0; b_addr = 32'd2112;
        for (int i = 0; i < 4; i++) begin
            wait_sig(0, 40, g);
            vectors++;
            if (g < 0 || {a_gnt, b_gnt, c_addr} !== {~i[0], i[0], (i[0] ? 32'd2112 : 32'd1088)}) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got cyc %0d gnt A%b B%b addr %0d expected %s",
                         i, g, a_gnt, b_gnt, c_addr, i[0] ? "B addr 2112" : "A addr 1088");
            end
            if (i == 3) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            wait_sig(1, 40, d);
            e = sb.pop_front();
            vectors++;
            if (d < 0 || done_obs() !== {~e.who, e.who, e.err, e.rdata}) begin
                errors++;
                $display("FAIL contention_done[%0d]: got cyc %0d obs %h expected %h",
                         i, d, done_obs(), {~e.who, e.who, e.err, e.rdata});
            end
        end
    endtask

    task automatic test_backpressure();
        int g, d;
        exp_t e;
        rdy_wait = 5;
        push_exp(1'b1, 1'b0, 32'h0000_5A5A);   // write keeps previous b_rdata
        drive_req(1'b1, 1'b1, 32'd3136, 32'd333);
        wait_sig(0, 20, g);
        b_req = 1'b0; b_addr = '1; b_wdata = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (g < 0 || {c_req, c_op, c_addr, c_wdata} !== {1'b1, 1'b1, 32'd3136, 32'd333}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got req %b op %b addr %0d wdata %0d expected 1 1 3136 333",
                         k, c_req, c_op, c_addr, c_wdata);
            end
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (c_req !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept: got c_req %b expected 0", c_req);
        end
        rdy_wait = 0;
        wait_sig(1, 20, d);
        e = sb.pop_front();
        vectors++;
        if (d < 0 || done_obs() !== {~e.who, e.who, e.err, e.rdata}) begin
            errors++;
            $display("FAIL backpressure_done: got cyc %0d obs %h expected %h",
                     d, done_obs(), {~e.who, e.who, e.err, e.rdata});
        end
    endtask

    task automatic test_timeout();
        int g, d, spurious;
        exp_t e;
        mute = 1'b1;
        push_exp(1'b1, 1'b1, 32'd0);
        drive_req(1'b1, 1'b0, 32'd4160, 32'd0);
        wait_sig(0, 20, g);
        b_req = 1'b0;
        wait_sig(1, 40, d);
        e = sb.pop_front();
        vectors++;
        if (g < 0 || d !== g + TIMEOUT || done_obs() !== {~e.who, e.who, e.err, e.rdata} || c_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got gnt %0d done %0d obs %h c_req %b expected done %0d obs %h c_req 0",
                     g, d, done_obs(), c_req, g + TIMEOUT, {~e.who, e.who, e.err, e.rdata});
        end
        @(negedge clk); inject_done = 1'b1;
        @(negedge clk); inject_done = 1'b0;
        spurious = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_done || b_done || c_req) spurious++;
        end
        vectors++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL timeout_late_done: got %0d spurious cycles expected 0", spurious);
        end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid();
        int g, d, seen;
        exp_t e;
        mute = 1'b1;
        drive_req(1'b1, 1'b0, 32'd5184, 32'd0);
        wait_sig(0, 20, g);
        b_req = 1'b0;
        @(negedge clk);           // now waiting on the cache
        rst_n = 1'b0;
        #1;
        vectors++;
        if (g < 0 || all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        mute  = 1'b0;
        seen  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_done || b_done || c_req) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_abandon: got %0d activity cycles expected 0", seen);
        end
        push_exp(1'b0, 1'b0, 32'h0000_A5A5);
        push_exp(1'b1, 1'b0, 32'h0000_5A5A);
        @(negedge clk);
        a_req = 1'b1; a_op = 1'b0; a_addr = 32'd1088;
        b_req = 1'b1; b_op = 1'b0; b_addr = 32'd2112;
        for (int i = 0; i < 2; i++) begin
            wait_sig(0, 20, g);
            vectors++;
            if (g < 0 || {a_gnt, b_gnt} !== {~i[0], i[0]}) begin
                errors++;
                $display("FAIL reset_mid_grant[%0d]: got A%b B%b expected A%b B%b",
                         i, a_gnt, b_gnt, ~i[0], i[0]);
            end
            if (i == 0) a_req = 1'b0; else b_req = 1'b0;
            wait_sig(1, 20, d);
            e = sb.pop_front();
            vectors++;
            if (d < 0 || done_obs() !== {~e.who, e.who, e.err, e.rdata}) begin
                errors++;
                $display("FAIL reset_mid_done[%0d]: got obs %h expected %h",
                         i, done_obs(), {~e.who, e.who, e.err, e.rdata});
            end
        end
    endtask

    task automatic test_write_hold();
        int g, d;
        exp_t e;
        mem[32'd7232] = 32'd5000;
        mem[32'd8256] = 32'd4242;   // returned on the write; must not land
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b0, 1'b0, 32'd5000);
            drive_req(1'b0, (k == 1), (k == 0) ? 32'd7232 : 32'd8256, 32'd9);
            wait_sig(0, 20, g);
            a_req = 1'b0;
            wait_sig(1, 20, d);
            e = sb.pop_front();
            vectors++;
            if (g < 0 || d < 0 || done_obs() !== {~e.who, e.who, e.err, e.rdata}) begin
                errors++;
                $display("FAIL write_hold[%0d]: got obs %h expected %h",
                         k, done_obs(), {~e.who, e.who, e.err, e.rdata});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_write_hold();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
